// File: rtl/vga_timing.sv
// VGA raster timing generator with a one-cycle registered output stage.
// Optional build macro VGA_TIMING_TEST_PATTERN_EN replaces pix_* with 8 colour bars.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        active,
  output logic        frame_start,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vga_out_t;

  localparam vga_out_t OUT_RST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0,
                                   r: 8'h00, g: 8'h00, b: 8'h00};

  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  vga_out_t    out_q, out_d;

  logic h_wrap, v_wrap, hs_on, vs_on;
  logic [7:0] src_r, src_g, src_b;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);
  assign hs_on  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs_on  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign frame_start = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  // Bar index only matters while active, where h_cnt < H_ACTIVE keeps it in 0..7.
  logic [18:0] h_x8;
  logic [2:0]  bar_idx;
  assign h_x8    = {h_cnt_q, 3'b000};
  assign bar_idx = 3'(h_x8 / 19'(H_ACTIVE));
  assign src_r   = {8{bar_idx[2]}};
  assign src_g   = {8{bar_idx[1]}};
  assign src_b   = {8{bar_idx[0]}};
`else
  assign src_r = pix_r;
  assign src_g = pix_g;
  assign src_b = pix_b;
`endif

  always_comb begin
    h_cnt_d     = h_cnt_q + 16'd1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (h_wrap) begin
      h_cnt_d = 16'd0;
      if (v_wrap) begin
        v_cnt_d     = 16'd0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        v_cnt_d = v_cnt_q + 16'd1;
      end
    end
  end

  // Sync, DE and blanked RGB share one register so every pin lines up.
  always_comb begin
    out_d    = OUT_RST;
    out_d.hs = hs_on ? SYNC_POL : ~SYNC_POL;
    out_d.vs = vs_on ? SYNC_POL : ~SYNC_POL;
    out_d.de = active;
    if (active) begin
      out_d.r = src_r;
      out_d.g = src_g;
      out_d.b = src_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= 16'd0;
      v_cnt_q     <= 16'd0;
      frame_cnt_q <= 16'd0;
      out_q       <= OUT_RST;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      out_q       <= out_d;
    end
  end

  assign vga_hsync = out_q.hs;
  assign vga_vsync = out_q.vs;
  assign vga_de    = out_q.de;
  assign vga_r     = out_q.r;
  assign vga_g     = out_q.g;
  assign vga_b     = out_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: full 800-clk lines, frame shortened to 15 lines.
module tb_vga_timing;
  localparam int HT = 800;
  localparam int VT = 15;   // 8 active + 2 fp + 2 sync + 3 bp
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] x, y, frame_cnt;
  logic        active, frame_start;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        vga_hsync, vga_vsync, vga_de;
  logic [7:0]  vga_r, vga_g, vga_b;

  int total = 0;
  int bad   = 0;

  assign pix_r = 8'hAA;
  assign pix_g = x[7:0];
  assign pix_b = 8'h33;

  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active),
    .frame_start(frame_start), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected registered RGB for an active pixel at horizontal count h.
  function automatic logic [23:0] exp_rgb(input int h);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    int bar;
    bar = (h * 8) / 640;
    return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`else
    return {8'hAA, 8'(h), 8'h33};
`endif
  endfunction

  initial begin
    int hs_first = -1, hs_first1 = -1, hs_n0 = 0;
    int de_first = -1, de_n0 = 0, de_f0 = 0;
    int vs_first = -1, vs_n = 0;
    int fs_n = 0, fs_second = -1;
    int rgb_bad = 0, de_bad = 0, hs_bad = 0;
    logic [23:0] e_rgb;
    logic        e_de, e_hs;
    int h, v;

    repeat (5) @(negedge clk);
    chk("rst_hsync", {31'd0, vga_hsync}, 32'd1);
    chk("rst_vsync", {31'd0, vga_vsync}, 32'd1);
    chk("rst_de", {31'd0, vga_de}, 32'd0);
    chk("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_frame_start", {31'd0, frame_start}, 32'd1);
    chk("rel_xy", {x, y}, 32'd0);

    // k = number of rising edges since reset release, sampled on the falling edge.
    for (int k = 0; k <= 2 * FR; k++) begin
      if (k > 0) @(negedge clk);
      h = (k - 1) % HT;
      v = ((k - 1) / HT) % VT;
      e_de  = (k > 0) && (h < 640) && (v < 8);
      e_hs  = !((k > 0) && (h >= 656) && (h < 752));
      e_rgb = e_de ? exp_rgb(h) : 24'd0;
      if (vga_de !== e_de) de_bad++;
      if (vga_hsync !== e_hs) hs_bad++;
      if ({vga_r, vga_g, vga_b} !== e_rgb) rgb_bad++;
      if (k < HT && !vga_hsync) begin hs_n0++; if (hs_first < 0) hs_first = k; end
      if (k >= HT && k < 2 * HT && !vga_hsync && hs_first1 < 0) hs_first1 = k;
      if (k < HT && vga_de) begin de_n0++; if (de_first < 0) de_first = k; end
      if (k < FR && vga_de) de_f0++;
      if (k < FR && !vga_vsync) begin vs_n++; if (vs_first < 0) vs_first = k; end
      if (frame_start) begin fs_n++; if (k > 0 && fs_second < 0) fs_second = k; end
      if (k == 5) chk("x_at_5", {16'd0, x}, 32'd5);
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (k == 6) chk("g_pix5", {24'd0, vga_g}, 32'h00);
`else
      if (k == 6) chk("g_pix5", {24'd0, vga_g}, 32'h05);
`endif
      if (k == HT) chk("line1_xy", {x, y}, {16'd0, 16'd1});
      if (k == FR) chk("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);
      if (k == 2 * FR) chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);
    end
    chk("hsync_first", hs_first, 657);
    chk("hsync_width", hs_n0, 96);
    chk("line_period", hs_first1 - hs_first, HT);
    chk("de_first", de_first, 1);
    chk("de_width", de_n0, 640);
    chk("de_per_frame", de_f0, 8 * 640);
    chk("vsync_first", vs_first, 10 * HT + 1);
    chk("vsync_width", vs_n, 1600);
    chk("frame_period", fs_second, FR);
    chk("frame_start_cnt", fs_n, 3);
    chk("de_pattern", de_bad, 0);
    chk("hsync_pattern", hs_bad, 0);
    chk("rgb_blanking", rgb_bad, 0);

    // Mid-frame asynchronous reset at line 5, pixel 300.
    repeat (5 * HT + 300) @(negedge clk);
    chk("pre_rst_xy", {x, y}, {16'd300, 16'd5});
    chk("pre_rst_de", {31'd0, vga_de}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_xy", {x, y}, 32'd0);
    chk("mid_rst_de", {31'd0, vga_de}, 32'd0);
    chk("mid_rst_sync", {30'd0, vga_hsync, vga_vsync}, 32'd3);
    chk("mid_rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("mid_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerel_frame_start", {31'd0, frame_start}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rerel_xy", {x, y}, {16'd3, 16'd0});
    chk("rerel_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
